// File: rtl/mode_select_if.sv
// mode_select_if: switch/lock inputs and committed-mode outputs of the mode selector
interface mode_select_if #(parameter int NUM_SW = 2);
  logic [NUM_SW-1:0] sw;
  logic lock;
  logic [NUM_SW-1:0] mode;
  logic [2**NUM_SW-1:0] mode_onehot;
  logic mode_valid;
  logic mode_changed;
  modport master (output sw, lock, input mode, mode_onehot, mode_valid, mode_changed);
  modport slave (input sw, lock, output mode, mode_onehot, mode_valid, mode_changed);
endinterface

// File: rtl/mode_select.sv
// mode_select: debounced, lockable mode selector with a timed safe drain into non-zero modes
module mode_select #(
  parameter int NUM_SW = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int SETTLE_CYCLES = 1000
) (
  input logic clk,
  input logic reset,
  mode_select_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int DW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_MAX = DW'(SETTLE_CYCLES - 1);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [NUM_SW-1:0] meta, s, cand, deb;
  logic [CW-1:0] cnt;
  logic [NUM_SW-1:0] target, target_n, mode, mode_n;
  logic [DW-1:0] drain_cnt, drain_cnt_n;
  logic valid, valid_n, changed, changed_n;
  assign bus.mode = mode;
  assign bus.mode_onehot = {{(2**NUM_SW-1){1'b0}}, 1'b1} << mode;
  assign bus.mode_valid = valid;
  assign bus.mode_changed = changed;
  // two-flop synchroniser for the raw switch levels
  always_ff @(posedge clk) begin
    if (reset) {meta, s} <= '0;
    else {meta, s} <= {bus.sw, meta};
  end
  // debouncer: deb follows s only after it has held steady long enough; cnt saturates
  always_ff @(posedge clk) begin
    if (reset) begin
      cand <= '0;
      cnt <= '0;
      deb <= '0;
    end else if (s != cand) begin
      cand <= s;
      cnt <= '0;
    end else if (cnt == CNT_MAX) deb <= cand;
    else cnt <= cnt + 1'b1;
  end
  // FSM state and committed-mode registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      target <= '0;
      drain_cnt <= '0;
      mode <= '0;
      valid <= 1'b1;
      changed <= 1'b0;
    end else begin
      state <= state_n;
      target <= target_n;
      drain_cnt <= drain_cnt_n;
      mode <= mode_n;
      valid <= valid_n;
      changed <= changed_n;
    end
  end
  // next state: mode 0 commits at once, non-zero modes go through a drain; a new deb during drain wins over the commit
  always_comb begin
    state_n = state;
    target_n = target;
    drain_cnt_n = drain_cnt;
    mode_n = mode;
    valid_n = valid;
    changed_n = 1'b0;
    if (state == RUN) begin
      if (!bus.lock && deb != mode) begin
        mode_n = '0;
        if (deb == '0) changed_n = 1'b1;
        else begin
          state_n = DRAIN;
          target_n = deb;
          drain_cnt_n = '0;
          valid_n = 1'b0;
        end
      end
    end else if (deb != target) begin
      if (deb == '0) begin
        state_n = RUN;
        valid_n = 1'b1;
        changed_n = 1'b1;
      end else begin
        target_n = deb;
        drain_cnt_n = '0;
      end
    end else if (drain_cnt == DRAIN_MAX) begin
      state_n = RUN;
      mode_n = target;
      valid_n = 1'b1;
      changed_n = 1'b1;
    end else drain_cnt_n = drain_cnt + 1'b1;
  end
endmodule

// File: tb/tb_mode_select.sv
// tb_mode_select: randomized and directed checks of mode_select against a behavioural model
module tb_mode_select;
  localparam int DEB = 4;
  localparam int SET = 3;
  logic clk = 0;
  logic reset;
  int checks = 0;
  int errors = 0;
  bit started = 0;
  mode_select_if #(.NUM_SW(2)) bus ();
  mode_select #(.NUM_SW(2), .DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SET)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  // model state: raw-input pipeline, window of recent synchronised samples, mode bookkeeping
  logic [1:0] p1, p2, deb_m, mode_m, tgt_m;
  logic [1:0] hist [0:DEB];
  bit valid_m, chg_m, draining;
  int left_m;
  task automatic model_step();
    logic [1:0] s_now, new_deb;
    bit same;
    if (reset) begin
      p1 = 0; p2 = 0; deb_m = 0; mode_m = 0; tgt_m = 0;
      for (int i = 0; i <= DEB; i++) hist[i] = 0;
      valid_m = 1; chg_m = 0; draining = 0; left_m = 0;
    end else begin
      s_now = p2;
      for (int i = 0; i < DEB; i++) hist[i] = hist[i+1];
      hist[DEB] = s_now;
      same = 1;
      for (int i = 0; i <= DEB; i++) if (hist[i] != s_now) same = 0;
      new_deb = same ? s_now : deb_m;
      chg_m = 0;
      if (draining) begin
        if (deb_m != tgt_m && deb_m == 0) begin
          mode_m = 0; valid_m = 1; chg_m = 1; draining = 0;
        end else if (deb_m != tgt_m) begin
          tgt_m = deb_m; left_m = SET;
        end else if (left_m == 1) begin
          mode_m = tgt_m; valid_m = 1; chg_m = 1; draining = 0;
        end else left_m--;
      end else if (!bus.lock && deb_m != mode_m) begin
        mode_m = 0;
        if (deb_m == 0) chg_m = 1;
        else begin
          draining = 1; tgt_m = deb_m; left_m = SET; valid_m = 0;
        end
      end
      deb_m = new_deb;
      p2 = p1;
      p1 = bus.sw;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    started = 1;
    #1;
  endtask
  task automatic lit(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (bus.mode !== mode_m || bus.mode_valid !== valid_m || bus.mode_changed !== chg_m ||
          bus.mode_onehot !== (4'b0001 << mode_m)) begin
        errors++;
        $display("FAIL outputs: mode=%0d valid=%0b chg=%0b onehot=%b expected mode=%0d valid=%0b chg=%0b onehot=%b at %0t",
                 bus.mode, bus.mode_valid, bus.mode_changed, bus.mode_onehot,
                 mode_m, valid_m, chg_m, 4'b0001 << mode_m, $time);
      end
    end
  end
  task automatic wait_drain(string name);
    int n = 0;
    while (bus.mode_valid && n < 30) begin
      tick();
      n++;
    end
    if (bus.mode_valid) lit({name, "_timeout"}, 1, 0);
  endtask
  initial begin
    int lows, pulses;
    reset = 1; bus.sw = 2'b11; bus.lock = 0;
    tick(); tick();
    lit("rst_mode", bus.mode, 0);
    lit("rst_onehot", bus.mode_onehot, 4'b0001);
    lit("rst_valid", bus.mode_valid, 1);
    lit("rst_changed", bus.mode_changed, 0);
    reset = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 7) lit("boot_valid_e7", bus.mode_valid, 1);
      if (k == 8) lit("boot_valid_e8", bus.mode_valid, 0);
      if (k == 10) lit("boot_mode_e10", bus.mode, 0);
      if (k == 11) lit("boot_mode_e11", bus.mode, 3);
      if (k == 11) lit("boot_chg_e11", bus.mode_changed, 1);
      if (k == 12) lit("boot_chg_e12", bus.mode_changed, 0);
    end
    bus.sw = 2'b10;
    repeat (15) tick();
    lit("to2_mode", bus.mode, 2);
    pulses = 0;
    bus.sw = 2'b01;
    repeat (3) tick();
    bus.sw = 2'b10;
    repeat (15) begin
      tick();
      pulses += bus.mode_changed;
    end
    lit("glitch_mode", bus.mode, 2);
    lit("glitch_pulses", pulses, 0);
    lows = 0; pulses = 0;
    bus.sw = 2'b11;
    repeat (20) begin
      tick();
      lows += !bus.mode_valid;
      pulses += bus.mode_changed;
    end
    lit("to3_lows", lows, 3);
    lit("to3_pulses", pulses, 1);
    lit("to3_onehot", bus.mode_onehot, 4'b1000);
    bus.sw = 2'b00;
    repeat (12) tick();
    lit("to0_mode", bus.mode, 0);
    for (int r = 0; r < 2; r++) begin
      bus.lock = 1; bus.sw = 2'b11;
      repeat (10) tick();
      bus.sw = r ? 2'b01 : 2'b00;
      repeat (5) tick();
      bus.lock = 0;
      tick();
      lit("abort_drain_start", bus.mode_valid, 0);
      tick(); tick();
      if (r == 0) begin
        lit("abort_valid", bus.mode_valid, 1);
        lit("abort_chg", bus.mode_changed, 1);
      end else begin
        tick(); tick();
        lit("retarget_valid_e10", bus.mode_valid, 0);
        tick();
        lit("retarget_mode", bus.mode, 1);
        lit("retarget_chg", bus.mode_changed, 1);
      end
    end
    bus.lock = 1; bus.sw = 2'b10;
    repeat (20) tick();
    lit("lock_mode", bus.mode, 1);
    bus.lock = 0;
    tick();
    lit("unlock_drain", bus.mode_valid, 0);
    repeat (3) tick();
    lit("unlock_mode", bus.mode, 2);
    bus.sw = 2'b11;
    wait_drain("middrain");
    reset = 1;
    tick();
    lit("middrain_mode", bus.mode, 0);
    lit("middrain_valid", bus.mode_valid, 1);
    lit("middrain_deb", dut.deb, 0);
    reset = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.sw = 2'($urandom);
      if ($urandom_range(0, 40) == 0) bus.lock = ~bus.lock;
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
